// File: rtl/mips_pipe_pkg.sv
// Shared definitions for the MIPS pipeline control slice: hazard FSM states,
// the hard-wired zero register and the branch flush depth.
package mips_pipe_pkg;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } hazard_state_e;

  localparam logic [4:0] REG_ZERO       = 5'd0;
  localparam int         BRANCH_PENALTY = 3;

endpackage

// File: rtl/hazard_stat_ctr.sv
// Saturating event counter: advances by one on each enabled cycle and sticks
// at all-ones; cleared by the asynchronous reset.
module hazard_stat_ctr #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc_i && (count_q != '1)) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage MIPS pipeline. Defining HAZARD_STATS_EN
// adds the saturating stall/flush/memory-wait statistics counters and ports.
module pipe_hazard_ctrl
   import mips_pipe_pkg::*;
#(
   parameter int CNT_W = 16
)
(
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       if_id_rs,
   input  logic [4:0]       if_id_rt,
   input  logic             if_id_uses_rt,
   input  logic             id_ex_memread,
   input  logic [4:0]       id_ex_rt,
   input  logic             ex_mem_branch,
   input  logic             ex_mem_zero,
   input  logic             ex_mem_memread,
   input  logic             ex_mem_memwrite,
   input  logic             dmem_ready,
   output logic             dmem_req,
   output logic             pc_en,
   output logic             pc_src,
   output logic             if_id_en,
   output logic             if_id_flush,
   output logic             id_ex_en,
   output logic             id_ex_flush,
   output logic             ex_mem_en,
   output logic             ex_mem_flush,
`ifdef HAZARD_STATS_EN
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt,
   output logic [CNT_W-1:0] memwait_cnt,
`endif
   output logic             mem_wb_flush
);

   hazard_state_e stateQ, stateD;

   logic memOp;
   logic memDone;
   logic freeze;
   logic takenBranch;
   logic loadUse;

   // A ready pulse only completes an access when a request is actually out.
   assign memOp   = ex_mem_memread | ex_mem_memwrite;
   assign memDone = memOp & dmem_ready;
   assign freeze  = ~rst & ~memDone & ((stateQ == MEM_WAIT) | memOp);

   assign takenBranch = ~rst & ~freeze & ex_mem_branch & ex_mem_zero;
   assign loadUse     = ~rst & ~freeze & ~takenBranch & id_ex_memread &
                        (id_ex_rt != REG_ZERO) &
                        ((id_ex_rt == if_id_rs) | (if_id_uses_rt & (id_ex_rt == if_id_rt)));

   assign dmem_req = memOp & ~rst;

   // State register: reset returns the sequencer to RUN, abandoning any access.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stateQ <= RUN;
      end else begin
         stateQ <= stateD;
      end
   end

   // Freeze wins over a branch flush, which in turn squashes a load-use stall.
   always_comb begin
      stateD       = stateQ;
      pc_en        = 1'b1;
      pc_src       = 1'b0;
      if_id_en     = 1'b1;
      if_id_flush  = 1'b0;
      id_ex_en     = 1'b1;
      id_ex_flush  = 1'b0;
      ex_mem_en    = 1'b1;
      ex_mem_flush = 1'b0;
      mem_wb_flush = 1'b0;

      case (stateQ)
         RUN:      if (memOp && !dmem_ready) stateD = MEM_WAIT;
         MEM_WAIT: if (memDone) stateD = RUN;
         default:  stateD = RUN;
      endcase

      if (freeze) begin
         pc_en        = 1'b0;
         if_id_en     = 1'b0;
         id_ex_en     = 1'b0;
         ex_mem_en    = 1'b0;
         mem_wb_flush = 1'b1;
      end else if (takenBranch) begin
         pc_src = 1'b1;
         {ex_mem_flush, id_ex_flush, if_id_flush} = {BRANCH_PENALTY{1'b1}};
      end else if (loadUse) begin
         pc_en       = 1'b0;
         if_id_en    = 1'b0;
         id_ex_flush = 1'b1;
      end
   end

`ifdef HAZARD_STATS_EN
   hazard_stat_ctr #(.W(CNT_W)) u_stall_ctr (
      .clk     (clk),
      .rst     (rst),
      .inc_i   (loadUse),
      .count_o (stall_cnt)
   );

   hazard_stat_ctr #(.W(CNT_W)) u_flush_ctr (
      .clk     (clk),
      .rst     (rst),
      .inc_i   (takenBranch),
      .count_o (flush_cnt)
   );

   hazard_stat_ctr #(.W(CNT_W)) u_memwait_ctr (
      .clk     (clk),
      .rst     (rst),
      .inc_i   (stateQ == MEM_WAIT),
      .count_o (memwait_cnt)
   );
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl; statistics checks are active only
// when HAZARD_STATS_EN is defined (counters built with CNT_W = 4).
module tb_pipe_hazard_ctrl;

   localparam int CNT_W = 4;

   typedef struct packed {
      logic       rst;
      logic [4:0] rs;
      logic [4:0] rt;
      logic       usesRt;
      logic       idExMemread;
      logic [4:0] idExRt;
      logic       branch;
      logic       zero;
      logic       memread;
      logic       memwrite;
      logic       ready;
   } stim_t;

   // {dmem_req, pc_en, pc_src, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
   //  ex_mem_en, ex_mem_flush, mem_wb_flush}
   localparam logic [9:0] EXP_RUN        = 10'b0101010100;
   localparam logic [9:0] EXP_RUN_REQ    = 10'b1101010100;
   localparam logic [9:0] EXP_FREEZE     = 10'b1000000001;
   localparam logic [9:0] EXP_BRANCH     = 10'b0111111110;
   localparam logic [9:0] EXP_BRANCH_REQ = 10'b1111111110;
   localparam logic [9:0] EXP_STALL      = 10'b0000011100;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [4:0] if_id_rs = '0;
   logic [4:0] if_id_rt = '0;
   logic       if_id_uses_rt = 1'b0;
   logic       id_ex_memread = 1'b0;
   logic [4:0] id_ex_rt = '0;
   logic       ex_mem_branch = 1'b0;
   logic       ex_mem_zero = 1'b0;
   logic       ex_mem_memread = 1'b0;
   logic       ex_mem_memwrite = 1'b0;
   logic       dmem_ready = 1'b0;
   logic       dmem_req, pc_en, pc_src, if_id_en, if_id_flush;
   logic       id_ex_en, id_ex_flush, ex_mem_en, ex_mem_flush, mem_wb_flush;
`ifdef HAZARD_STATS_EN
   logic [CNT_W-1:0] stall_cnt, flush_cnt, memwait_cnt;
`endif

   logic [9:0] obs;
   logic [9:0] expQ[$];
   int         passCount = 0;
   int         checkCount = 0;

   // Free-running 10-time-unit clock.
   always #5 clk = ~clk;

   pipe_hazard_ctrl #(.CNT_W(CNT_W)) dut (
      .clk             (clk),
      .rst             (rst),
      .if_id_rs        (if_id_rs),
      .if_id_rt        (if_id_rt),
      .if_id_uses_rt   (if_id_uses_rt),
      .id_ex_memread   (id_ex_memread),
      .id_ex_rt        (id_ex_rt),
      .ex_mem_branch   (ex_mem_branch),
      .ex_mem_zero     (ex_mem_zero),
      .ex_mem_memread  (ex_mem_memread),
      .ex_mem_memwrite (ex_mem_memwrite),
      .dmem_ready      (dmem_ready),
      .dmem_req        (dmem_req),
      .pc_en           (pc_en),
      .pc_src          (pc_src),
      .if_id_en        (if_id_en),
      .if_id_flush     (if_id_flush),
      .id_ex_en        (id_ex_en),
      .id_ex_flush     (id_ex_flush),
      .ex_mem_en       (ex_mem_en),
      .ex_mem_flush    (ex_mem_flush),
`ifdef HAZARD_STATS_EN
      .stall_cnt       (stall_cnt),
      .flush_cnt       (flush_cnt),
      .memwait_cnt     (memwait_cnt),
`endif
      .mem_wb_flush    (mem_wb_flush)
   );

   assign obs = {dmem_req, pc_en, pc_src, if_id_en, if_id_flush,
                 id_ex_en, id_ex_flush, ex_mem_en, ex_mem_flush, mem_wb_flush};

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual === expected) passCount++;
      else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
   endtask

   // One cycle: drive at the falling edge, queue the expectation, compare mid-low phase.
   task automatic applyStimulus(input string tag, input stim_t s, input logic [9:0] expected);
      logic [9:0] want;
      @(negedge clk);
      rst             = s.rst;
      if_id_rs        = s.rs;
      if_id_rt        = s.rt;
      if_id_uses_rt   = s.usesRt;
      id_ex_memread   = s.idExMemread;
      id_ex_rt        = s.idExRt;
      ex_mem_branch   = s.branch;
      ex_mem_zero     = s.zero;
      ex_mem_memread  = s.memread;
      ex_mem_memwrite = s.memwrite;
      dmem_ready      = s.ready;
      expQ.push_back(expected);
      #2;
      if (expQ.size() == 0) begin
         checkOutput({tag, "_queue"}, 32'(expQ.size()), 32'd1);
      end else begin
         want = expQ.pop_front();
         checkOutput(tag, 32'(obs), 32'(want));
      end
   endtask

   task automatic checkCounters(input string tag, input int s, input int f, input int m);
      @(posedge clk);
      #1;
`ifdef HAZARD_STATS_EN
      checkOutput({tag, "_stall"}, 32'(stall_cnt), s);
      checkOutput({tag, "_flush"}, 32'(flush_cnt), f);
      checkOutput({tag, "_memwait"}, 32'(memwait_cnt), m);
`else
      if (s + f + m < 0) $display("[TB] negative counter expectation in %s", tag);
`endif
   endtask

   function automatic stim_t loadUseStim(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic usesRt, input logic [4:0] ldRt);
      stim_t s = '0;
      s.rs = rs; s.rt = rt; s.usesRt = usesRt; s.idExMemread = 1'b1; s.idExRt = ldRt;
      return s;
   endfunction

   function automatic stim_t memStim(input logic rd, input logic wr, input logic rdy);
      stim_t s = '0;
      s.memread = rd; s.memwrite = wr; s.ready = rdy;
      return s;
   endfunction

   function automatic stim_t branchStim(input logic zero);
      stim_t s = '0;
      s.branch = 1'b1; s.zero = zero;
      return s;
   endfunction

   // Directed sequence covering load-use, memory wait, branch priority, reset and saturation.
   initial begin
      stim_t s;

      s = stim_t'(memStim(1'b1, 1'b0, 1'b0) | branchStim(1'b1) | loadUseStim(5'd5, 5'd0, 1'b0, 5'd5));
      s.rst = 1'b1;
      applyStimulus("reset_outputs", s, EXP_RUN);
      checkCounters("reset", 0, 0, 0);

      applyStimulus("lu_rs_match", loadUseStim(5'd5, 5'd9, 1'b0, 5'd5), EXP_STALL);
      applyStimulus("lu_release", stim_t'('0), EXP_RUN);
      applyStimulus("lu_reg_zero", loadUseStim(5'd0, 5'd0, 1'b1, 5'd0), EXP_RUN);
      applyStimulus("lu_rt_match", loadUseStim(5'd3, 5'd7, 1'b1, 5'd7), EXP_STALL);
      applyStimulus("lu_rt_unused", loadUseStim(5'd3, 5'd7, 1'b0, 5'd7), EXP_RUN);
      checkCounters("after_lu", 2, 0, 0);

      for (int i = 0; i < 3; i++) applyStimulus("mem_freeze", memStim(1'b1, 1'b0, 1'b0), EXP_FREEZE);
      applyStimulus("mem_done", memStim(1'b1, 1'b0, 1'b1), EXP_RUN_REQ);
      applyStimulus("mem_back_run", stim_t'('0), EXP_RUN);
      applyStimulus("mem_single_cycle", memStim(1'b0, 1'b1, 1'b1), EXP_RUN_REQ);
      checkCounters("after_mem", 2, 0, 3);

      applyStimulus("br_taken", branchStim(1'b1), EXP_BRANCH);
      applyStimulus("br_not_taken", branchStim(1'b0), EXP_RUN);
      applyStimulus("br_over_lu", stim_t'(branchStim(1'b1) | loadUseStim(5'd4, 5'd0, 1'b0, 5'd4)), EXP_BRANCH);
      checkCounters("after_br", 2, 2, 3);

      applyStimulus("freeze_over_br", stim_t'(memStim(1'b1, 1'b0, 1'b0) | branchStim(1'b1)), EXP_FREEZE);
      applyStimulus("br_on_mem_done", stim_t'(memStim(1'b1, 1'b0, 1'b1) | branchStim(1'b1)), EXP_BRANCH_REQ);
      checkCounters("after_freeze_br", 2, 3, 4);

      applyStimulus("stray_ready", memStim(1'b0, 1'b0, 1'b1), EXP_RUN);

      applyStimulus("wait_enter", memStim(1'b1, 1'b0, 1'b0), EXP_FREEZE);
      s = memStim(1'b1, 1'b0, 1'b0);
      s.rst = 1'b1;
      applyStimulus("rst_in_wait", s, EXP_RUN);
      checkCounters("rst_clear", 0, 0, 0);
      applyStimulus("rst_release_run", stim_t'('0), EXP_RUN);

      for (int i = 0; i < (1 << CNT_W) + 5; i++) begin
         applyStimulus("sat_stall", loadUseStim(5'd8, 5'd0, 1'b0, 5'd8), EXP_STALL);
      end
      checkCounters("saturate", (1 << CNT_W) - 1, 0, 0);

      $display("[TB] %0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
